// File: rtl/ps2_keycode_if.sv
// PS/2 keyboard-side lines plus the decoded key outputs of ps2_keycode.
// The master drives the PS/2 lines; the slave (the decoder) drives the results.
interface ps2_keycode_if;
    logic        ps2_clk;
    logic        ps2_data;
    logic [15:0] keycode;
    logic        key_valid;
    logic        frame_err;

    modport master (
        output ps2_clk,
        output ps2_data,
        input  keycode,
        input  key_valid,
        input  frame_err
    );

    modport slave (
        input  ps2_clk,
        input  ps2_data,
        output keycode,
        output key_valid,
        output frame_err
    );
endinterface

// File: rtl/ps2_keycode.sv
// PS/2 set-2 scan-code receiver that tracks one held key as a HID usage ID.
// Frames are sampled on synchronized ps2_clk falling edges; partial frames time out.
module ps2_keycode #(
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic          Clk,
    input  logic          Reset,
    ps2_keycode_if.slave  bus
);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LIMIT = TW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    // Odd parity holds when the data bits plus the parity bit contain an odd number of ones.
    function automatic logic parity_odd(input logic [8:0] bits);
        return ^bits;
    endfunction

    // Returns {hit, usage}; extended codes only match after an E0 prefix.
    function automatic logic [8:0] map_code(input logic ext, input logic [7:0] code);
        logic [8:0] r;
        r = 9'h000;
        if (ext) begin
            case (code)
                8'h75:   r = {1'b1, 8'd82};
                8'h72:   r = {1'b1, 8'd81};
                8'h6B:   r = {1'b1, 8'd80};
                8'h74:   r = {1'b1, 8'd79};
                default: r = 9'h000;
            endcase
        end else begin
            case (code)
                8'h1D:   r = {1'b1, 8'd26};
                8'h1C:   r = {1'b1, 8'd4};
                8'h1B:   r = {1'b1, 8'd22};
                8'h23:   r = {1'b1, 8'd7};
                8'h29:   r = {1'b1, 8'd44};
                8'h5A:   r = {1'b1, 8'd40};
                default: r = 9'h000;
            endcase
        end
        return r;
    endfunction

    logic          clk_meta_q, clk_meta_d, clk_sync_q, clk_sync_d, clk_prev_q, clk_prev_d;
    logic          data_meta_q, data_meta_d, data_sync_q, data_sync_d;
    state_t        state_q, state_d;
    logic [7:0]    shift_q, shift_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic          parity_q, parity_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          brk_q, brk_d, ext_q, ext_d;
    logic [7:0]    keycode_q, keycode_d;
    logic          key_valid_q, key_valid_d, frame_err_q, frame_err_d;
    logic          fall_s, frame_ok_s;
    logic [8:0]    mapped_s;

    // Next-state logic: synchronizers, frame FSM, timeout, prefix flags and key tracking.
    always_comb begin
        clk_meta_d  = bus.ps2_clk;
        clk_sync_d  = clk_meta_q;
        clk_prev_d  = clk_sync_q;
        data_meta_d = bus.ps2_data;
        data_sync_d = data_meta_q;
        state_d     = state_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        parity_d    = parity_q;
        brk_d       = brk_q;
        ext_d       = ext_q;
        keycode_d   = keycode_q;
        frame_err_d = 1'b0;
        key_valid_d = 1'b0;

        fall_s     = clk_prev_q & ~clk_sync_q;
        frame_ok_s = data_sync_q & parity_odd({parity_q, shift_q});
        mapped_s   = map_code(ext_q, shift_q);

        if (fall_s) begin
            tmo_d = '0;
        end else if (state_q != IDLE) begin
            tmo_d = tmo_q + TW'(1);
        end else begin
            tmo_d = '0;
        end

        // A falling edge in the same cycle as the timeout keeps the frame alive.
        if (!fall_s && (state_q != IDLE) && (tmo_q == TMO_LIMIT)) begin
            state_d = IDLE;
            tmo_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (fall_s && !data_sync_q) begin
                        state_d   = DATA;
                        bit_cnt_d = 3'd0;
                    end else begin
                        state_d = IDLE;
                    end
                end
                DATA: begin
                    if (fall_s) begin
                        shift_d = {data_sync_q, shift_q[7:1]};
                        if (bit_cnt_q == 3'd7) begin
                            state_d   = PARITY;
                            bit_cnt_d = 3'd0;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 3'd1;
                        end
                    end else begin
                        state_d = DATA;
                    end
                end
                PARITY: begin
                    if (fall_s) begin
                        parity_d = data_sync_q;
                        state_d  = STOP;
                    end else begin
                        state_d = PARITY;
                    end
                end
                STOP: begin
                    if (fall_s) begin
                        state_d = IDLE;
                        if (!frame_ok_s) begin
                            frame_err_d = 1'b1;
                            brk_d       = 1'b0;
                            ext_d       = 1'b0;
                        end else if (shift_q == 8'hF0) begin
                            brk_d = 1'b1;
                        end else if (shift_q == 8'hE0) begin
                            ext_d = 1'b1;
                        end else begin
                            brk_d = 1'b0;
                            ext_d = 1'b0;
                            if (!mapped_s[8]) begin
                                keycode_d = keycode_q;
                            end else if (!brk_q) begin
                                keycode_d = mapped_s[7:0];
                            end else if (keycode_q == mapped_s[7:0]) begin
                                keycode_d = 8'h00;
                            end else begin
                                keycode_d = keycode_q;
                            end
                        end
                    end else begin
                        state_d = STOP;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        key_valid_d = (keycode_d != keycode_q);
    end

    // State register; synchronizers reset to the idle-high bus level.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            clk_meta_q  <= 1'b1;
            clk_sync_q  <= 1'b1;
            clk_prev_q  <= 1'b1;
            data_meta_q <= 1'b1;
            data_sync_q <= 1'b1;
            state_q     <= IDLE;
            shift_q     <= 8'h00;
            bit_cnt_q   <= 3'd0;
            parity_q    <= 1'b0;
            tmo_q       <= '0;
            brk_q       <= 1'b0;
            ext_q       <= 1'b0;
            keycode_q   <= 8'h00;
            key_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            clk_meta_q  <= clk_meta_d;
            clk_sync_q  <= clk_sync_d;
            clk_prev_q  <= clk_prev_d;
            data_meta_q <= data_meta_d;
            data_sync_q <= data_sync_d;
            state_q     <= state_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            parity_q    <= parity_d;
            tmo_q       <= tmo_d;
            brk_q       <= brk_d;
            ext_q       <= ext_d;
            keycode_q   <= keycode_d;
            key_valid_q <= key_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign bus.keycode   = {8'h00, keycode_q};
    assign bus.key_valid = key_valid_q;
    assign bus.frame_err = frame_err_q;
endmodule

// File: tb/tb_ps2_keycode.sv
// Self-checking bench for ps2_keycode: directed scenarios plus random frames
// checked against a table-driven model of the held-key rules.
module tb_ps2_keycode;
    localparam int TMO = 200;

    logic Clk = 1'b0;
    logic Reset = 1'b1;
    always #5 Clk = ~Clk;

    ps2_keycode_if bus();

    ps2_keycode #(.TIMEOUT_CYCLES(TMO)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    int vec_cnt = 0;
    int err_cnt = 0;
    int kv_cnt  = 0;
    int fe_cnt  = 0;
    int exp_key = 0;
    int exp_kv  = 0;
    int exp_fe  = 0;
    bit m_brk   = 1'b0;
    bit m_ext   = 1'b0;

    logic [7:0] nx_code [6] = '{8'h1D, 8'h1C, 8'h1B, 8'h23, 8'h29, 8'h5A};
    int         nx_use  [6] = '{26, 4, 22, 7, 44, 40};
    logic [7:0] ex_code [4] = '{8'h75, 8'h72, 8'h6B, 8'h74};
    int         ex_use  [4] = '{82, 81, 80, 79};

    // Pulse counters observed away from the active edge.
    always @(negedge Clk) begin
        if (bus.key_valid === 1'b1) kv_cnt++;
        if (bus.frame_err === 1'b1) fe_cnt++;
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    function automatic int lookup(input bit ext, input logic [7:0] b);
        int u;
        u = -1;
        if (ext) begin
            for (int i = 0; i < 4; i++) if (ex_code[i] == b) u = ex_use[i];
        end else begin
            for (int i = 0; i < 6; i++) if (nx_code[i] == b) u = nx_use[i];
        end
        return u;
    endfunction

    // Reference: what the held key becomes after one received byte.
    task automatic model_frame(input logic [7:0] b, input bit ok, output int new_key, output bit pulse);
        int u;
        new_key = exp_key;
        pulse   = 1'b0;
        if (!ok) begin
            exp_fe++;
            m_brk = 1'b0;
            m_ext = 1'b0;
        end else if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else begin
            u = lookup(m_ext, b);
            if (u >= 0) begin
                if (!m_brk) new_key = u;
                else if (exp_key == u) new_key = 0;
            end
            m_brk = 1'b0;
            m_ext = 1'b0;
        end
        if (new_key != exp_key) begin
            pulse = 1'b1;
            exp_kv++;
        end
        exp_key = new_key;
    endtask

    task automatic ps2_bit(input logic b);
        bus.ps2_data = b;
        wait_cyc(4);
        bus.ps2_clk = 1'b0;
        wait_cyc(4);
        bus.ps2_clk = 1'b1;
        wait_cyc(4);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop, input string name);
        logic [10:0] bits;
        logic        par;
        bit          ok, pulse;
        int          old_key, new_key;
        par     = (~^b) ^ bad_par;
        bits    = {~bad_stop, par, b, 1'b0};
        ok      = !bad_par && !bad_stop;
        old_key = exp_key;
        for (int i = 0; i < 11; i++) begin
            bus.ps2_data = bits[i];
            wait_cyc(4);
            bus.ps2_clk = 1'b0;
            if (i == 10) begin
                wait_cyc(2);
                vec_cnt++;
                if (bus.keycode !== 16'(old_key)) begin
                    err_cnt++;
                    $display("FAIL %s early_keycode: got %0d want %0d", name, bus.keycode, old_key);
                end
                model_frame(b, ok, new_key, pulse);
                wait_cyc(1);
                vec_cnt++;
                if (bus.keycode !== 16'(new_key) || bus.key_valid !== pulse || bus.frame_err !== !ok) begin
                    err_cnt++;
                    $display("FAIL %s result: got key=%0d kv=%b fe=%b want key=%0d kv=%b fe=%b",
                             name, bus.keycode, bus.key_valid, bus.frame_err, new_key, pulse, !ok);
                end
                wait_cyc(1);
                vec_cnt++;
                if (bus.key_valid !== 1'b0 || bus.frame_err !== 1'b0) begin
                    err_cnt++;
                    $display("FAIL %s pulse_width: got kv=%b fe=%b want 0 0", name, bus.key_valid, bus.frame_err);
                end
                wait_cyc(2);
            end else begin
                wait_cyc(4);
            end
            bus.ps2_clk = 1'b1;
            wait_cyc(4);
        end
        vec_cnt++;
        if (kv_cnt != exp_kv || fe_cnt != exp_fe) begin
            err_cnt++;
            $display("FAIL %s pulse_count: got kv=%0d fe=%0d want kv=%0d fe=%0d", name, kv_cnt, fe_cnt, exp_kv, exp_fe);
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wait_cyc(1);
            vec_cnt++;
            if (bus.keycode !== 16'h0000 || bus.key_valid !== 1'b0 || bus.frame_err !== 1'b0) begin
                err_cnt++;
                $display("FAIL reset_outputs: got key=%0d kv=%b fe=%b want 0 0 0", bus.keycode, bus.key_valid, bus.frame_err);
            end
        end
        Reset = 1'b0;
        wait_cyc(5);
        vec_cnt++;
        if (bus.keycode !== 16'h0000 || kv_cnt != 0 || fe_cnt != 0) begin
            err_cnt++;
            $display("FAIL idle_after_reset: got key=%0d kv_cnt=%0d fe_cnt=%0d want 0 0 0", bus.keycode, kv_cnt, fe_cnt);
        end
    endtask

    task automatic test_make();
        send_frame(8'h1D, 1'b0, 1'b0, "make_w");
        send_frame(8'h1D, 1'b0, 1'b0, "repeat_w");
    endtask

    task automatic test_break();
        send_frame(8'hF0, 1'b0, 1'b0, "brk_prefix_a");
        send_frame(8'h1C, 1'b0, 1'b0, "brk_other_a");
        send_frame(8'hF0, 1'b0, 1'b0, "brk_prefix_w");
        send_frame(8'h1D, 1'b0, 1'b0, "brk_held_w");
    endtask

    task automatic test_extended();
        send_frame(8'hE0, 1'b0, 1'b0, "ext_prefix");
        send_frame(8'h75, 1'b0, 1'b0, "ext_up");
        send_frame(8'hE0, 1'b0, 1'b0, "ext_brk_e0");
        send_frame(8'hF0, 1'b0, 1'b0, "ext_brk_f0");
        send_frame(8'h75, 1'b0, 1'b0, "ext_brk_up");
        send_frame(8'h1D, 1'b0, 1'b0, "make_w2");
        send_frame(8'h75, 1'b0, 1'b0, "bare_75");
    endtask

    task automatic test_frame_err();
        send_frame(8'h1D, 1'b1, 1'b0, "bad_parity");
        send_frame(8'h23, 1'b0, 1'b0, "make_d");
        send_frame(8'h1C, 1'b0, 1'b1, "bad_stop");
        send_frame(8'hE0, 1'b0, 1'b0, "err_e0");
        send_frame(8'h72, 1'b1, 1'b0, "err_drop");
        send_frame(8'h72, 1'b0, 1'b0, "flag_cleared");
    endtask

    task automatic test_timeout();
        for (int i = 0; i < 5; i++) ps2_bit((i == 0) ? 1'b0 : 1'($urandom_range(0, 1)));
        wait_cyc(TMO + 10);
        vec_cnt++;
        if (fe_cnt != exp_fe || bus.keycode !== 16'(exp_key)) begin
            err_cnt++;
            $display("FAIL timeout_quiet: got fe_cnt=%0d key=%0d want %0d %0d", fe_cnt, bus.keycode, exp_fe, exp_key);
        end
        send_frame(8'h1C, 1'b0, 1'b0, "after_timeout");
    endtask

    task automatic test_reset_midframe();
        send_frame(8'h1D, 1'b0, 1'b0, "pre_rst_make");
        send_frame(8'hF0, 1'b0, 1'b0, "pre_rst_f0");
        for (int i = 0; i < 3; i++) ps2_bit(1'b0);
        Reset = 1'b1;
        wait_cyc(2);
        vec_cnt++;
        if (bus.keycode !== 16'h0000 || bus.key_valid !== 1'b0 || bus.frame_err !== 1'b0) begin
            err_cnt++;
            $display("FAIL midframe_reset: got key=%0d kv=%b fe=%b want 0 0 0", bus.keycode, bus.key_valid, bus.frame_err);
        end
        Reset   = 1'b0;
        exp_key = 0;
        m_brk   = 1'b0;
        m_ext   = 1'b0;
        bus.ps2_data = 1'b1;
        wait_cyc(4);
        send_frame(8'h1D, 1'b0, 1'b0, "post_rst_w");
        send_frame(8'h29, 1'b0, 1'b0, "post_rst_space");
    endtask

    task automatic test_random();
        logic [7:0] b;
        int         kind;
        for (int n = 0; n < 40; n++) begin
            kind = int'($urandom_range(0, 9));
            if (kind < 2)      b = 8'hF0;
            else if (kind < 3) b = 8'hE0;
            else if (kind < 6) b = nx_code[$urandom_range(0, 5)];
            else if (kind < 8) b = ex_code[$urandom_range(0, 3)];
            else               b = 8'($urandom_range(0, 255));
            send_frame(b, ($urandom_range(0, 9) == 0), ($urandom_range(0, 19) == 0), "random");
        end
    endtask

    initial begin
        bus.ps2_clk  = 1'b1;
        bus.ps2_data = 1'b1;
        test_reset();
        test_make();
        test_break();
        test_extended();
        test_frame_err();
        test_timeout();
        test_reset_midframe();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule

// File: doc/ps2_keycode.md
PS2_KEYCODE -- requirements
Module: ps2_keycode

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 50000, is the number of Clk cycles with no PS/2 falling edge after which a partial frame is abandoned.
REQ-002 Port: Clk  input  1  system clock; all state updates on the rising edge.
REQ-003 Port: Reset  input  1  synchronous, active-high reset.
REQ-004 Port: ps2_clk  input  1  PS/2 device clock, asynchronous to Clk.
REQ-005 Port: ps2_data  input  1  PS/2 device data, asynchronous to Clk.
REQ-006 Port: keycode  output  16  HID usage ID of the currently held mapped key in [7:0]; [15:8] always 0; 0 when no key is held.
REQ-007 Port: key_valid  output  1  one-cycle pulse when keycode changes value.
REQ-008 Port: frame_err  output  1  one-cycle pulse on a parity or stop-bit error.

Function
REQ-009 ps2_clk and ps2_data SHALL each pass through a 2-flop synchronizer before any use.
REQ-010 A falling edge SHALL be detected as: previous synced ps2_clk = 1 and current synced ps2_clk = 0; data is sampled only on that cycle.
REQ-011 The frame FSM SHALL have states IDLE, DATA, PARITY and STOP.
REQ-012 IDLE: on a falling edge, sampled data 0 -> DATA with bit count 0; sampled data 1 -> stay in IDLE with no error.
REQ-013 DATA: each falling edge shifts the sampled bit in LSB-first; after the 8th bit -> PARITY.
REQ-014 PARITY: the falling edge latches the parity bit -> STOP.
REQ-015 STOP: the falling edge -> IDLE; the byte is accepted only if the stop bit = 1 and the count of ones over the 8 data bits plus parity is odd.
REQ-016 On rejection, frame_err SHALL pulse for 1 cycle, the byte SHALL be discarded, and the break/extended flags SHALL be cleared.
REQ-017 Timeout: a counter clears on every falling edge and increments while the FSM is not in IDLE.
REQ-018 When the counter reaches TIMEOUT_CYCLES, the FSM SHALL return to IDLE with no frame_err.
REQ-019 If a falling edge and the timeout fall in the same cycle, the edge SHALL win.
REQ-020 Accepted byte 0xF0 SHALL set the break flag; accepted byte 0xE0 SHALL set the extended flag; neither changes keycode.
REQ-021 Any other accepted byte is a code byte and SHALL clear both flags after being processed.
REQ-022 Non-extended map (set 2 -> HID): 0x1D->26 (W), 0x1C->4 (A), 0x1B->22 (S), 0x23->7 (D), 0x29->44 (space), 0x5A->40 (enter).
REQ-023 Extended map: 0x75->82 (up), 0x72->81 (down), 0x6B->80 (left), 0x74->79 (right).
REQ-024 Mapped make code: keycode <= {8'h00, usage}.
REQ-025 Mapped break code: keycode <= 0 if keycode[7:0] equals that usage, otherwise keycode is unchanged.
REQ-026 Unmapped code bytes SHALL leave keycode unchanged.
REQ-027 Latency: when the STOP falling edge is detected in cycle N, keycode and any key_valid/frame_err pulse SHALL be visible in cycle N+1.
REQ-028 key_valid SHALL pulse only when the new keycode differs from the old value; a repeated make of the held key produces no pulse.

Reset
REQ-029 While Reset = 1 at a Clk edge: FSM -> IDLE; shift register, bit count, timeout counter and both flags -> 0.
REQ-030 While Reset = 1 at a Clk edge: keycode = 16'h0000, key_valid = 0, frame_err = 0; synchronizer flops -> 1 (bus idle).
REQ-031 Reset asserted mid-frame SHALL abandon the frame; the first valid frame after Reset deasserts SHALL decode normally.

Verification
REQ-032 Reset 3 cycles, idle bus -> keycode = 0, key_valid = 0, frame_err = 0 in every cycle.
REQ-033 Frame 0x1D with parity 1 and stop 1 -> keycode = 16'd26 one cycle after the stop edge, key_valid high for exactly 1 cycle; a second 0x1D -> no key_valid pulse.
REQ-034 With keycode = 26: send F0,1C -> keycode stays 26, no pulse; then send F0,1D -> keycode = 0 with one key_valid pulse.
REQ-035 Send E0,75 -> keycode = 16'd82; then send E0,F0,75 -> keycode = 0; send 0x75 without prefix -> keycode unchanged.
REQ-036 Frame 0x1D with parity 0 -> frame_err pulses once, keycode unchanged; next frame 0x23 -> keycode = 16'd7.
REQ-037 Drive start bit plus 4 data bits, then idle for TIMEOUT_CYCLES+10 -> FSM in IDLE, no frame_err; next full 0x1C frame -> keycode = 16'd4.
